// File: rtl/branch_history_table.sv
// Direct-mapped table of 2-bit saturating counters. Fetch reads a prediction;
// execute trains the table with resolved outcomes and tracks mispredict statistics.
module branch_history_table #(
  parameter int INDEX_BITS = 6,
  parameter int PC_WIDTH   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pred_req,
  input  logic [PC_WIDTH-1:0] pred_pc,
  input  logic                flush,
  output logic                pred_valid,
  output logic                pred_taken,
  input  logic                upd_valid,
  input  logic [PC_WIDTH-1:0] upd_pc,
  input  logic                upd_br_en,
  input  logic                upd_pred_taken,
  output logic                mispredict,
  output logic [31:0]         num_branches,
  output logic [31:0]         num_mispredicts
);

  // Handshake: pred_req and upd_valid are valid-only qualifiers with no ready;
  // every request and update is accepted in the cycle it is presented.
  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [1:0]            table_q [ENTRIES];
  logic [INDEX_BITS-1:0] pred_idx;
  logic [INDEX_BITS-1:0] upd_idx;
  logic [1:0]            upd_entry;
  logic [1:0]            upd_next;
  logic                  pred_fire;
  logic                  upd_miss;

  assign pred_idx  = pred_pc[INDEX_BITS+1:2];
  assign upd_idx   = upd_pc[INDEX_BITS+1:2];
  assign pred_fire = pred_req & ~flush;
  assign upd_miss  = upd_valid & (upd_br_en != upd_pred_taken);

  // Upper PC bits and the byte offset are deliberately not part of the index.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[PC_WIDTH-1:INDEX_BITS+2], pred_pc[1:0],
                            upd_pc[PC_WIDTH-1:INDEX_BITS+2], upd_pc[1:0]};

  always_comb begin
    upd_entry = table_q[upd_idx];
    upd_next  = upd_entry;
    if (upd_br_en) begin
      if (upd_entry != 2'b11) upd_next = upd_entry + 2'd1;
    end else begin
      if (upd_entry != 2'b00) upd_next = upd_entry - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= 2'b01;
    end else if (upd_valid) begin
      table_q[upd_idx] <= upd_next;
    end
  end

  // Reads see the pre-update entry: no bypass from a same-cycle update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
    end else begin
      pred_valid <= pred_fire;
      if (pred_fire) pred_taken <= table_q[pred_idx][1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict      <= 1'b0;
      num_branches    <= 32'd0;
      num_mispredicts <= 32'd0;
    end else begin
      mispredict <= upd_miss;
      if (upd_valid && num_branches != 32'hFFFF_FFFF)
        num_branches <= num_branches + 32'd1;
      if (upd_miss && num_mispredicts != 32'hFFFF_FFFF)
        num_mispredicts <= num_mispredicts + 32'd1;
    end
  end

endmodule

// File: doc/branch_history_table.md
# branch_history_table

Direct-mapped table of 2-bit saturating counters that predicts conditional branches for fetch and is trained by the execute stage using the resolved outcome from the branch comparator. It sits immediately downstream of the comparator: its update port consumes the comparator's taken/not-taken result and the fetch-time prediction, and it reports a registered mispredict pulse plus running statistics. The prediction port serves the fetch stage in the same cycle stream.

## Interface
- INDEX_BITS, 6, log2 of entry count; the table has 2^INDEX_BITS entries.
- PC_WIDTH, 32, width of program-counter inputs.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- pred_req  in  1  fetch requests a prediction this cycle.
- pred_pc  in  PC_WIDTH  PC of the fetched instruction.
- flush  in  1  drop the prediction requested this cycle.
- pred_valid  out  1  pred_taken is valid (one cycle after pred_req).
- pred_taken  out  1  predicted direction: 1 = taken.
- upd_valid  in  1  a conditional branch resolved in execute this cycle.
- upd_pc  in  PC_WIDTH  PC of the resolved branch.
- upd_br_en  in  1  resolved outcome from the comparator (1 = taken).
- upd_pred_taken  in  1  direction predicted at fetch for this branch.
- mispredict  out  1  one-cycle pulse: the last update disagreed with its prediction.
- num_branches  out  32  count of accepted updates.
- num_mispredicts  out  32  count of mispredicted updates.

## Operation
- Index = pc[INDEX_BITS+1:2]; bits [1:0] are ignored; upper bits are not stored (no tags, aliasing allowed).
- Entry encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken. Prediction = entry bit 1.
- Update on upd_valid: upd_br_en=1 increments the entry, saturating at 11; upd_br_en=0 decrements it, saturating at 00. Only the indexed entry changes.
- Mispredict = upd_valid & (upd_br_en != upd_pred_taken), registered.
- num_branches increments on every upd_valid; num_mispredicts increments on every mispredicting update. Both saturate at 32'hFFFF_FFFF, no wrap.
- Read/update same index in the same cycle: the prediction returns the pre-update entry value (no bypass); the update lands at that edge.
- flush: with pred_req and flush in the same cycle, pred_valid is 0 the next cycle. flush has no effect on the table, on updates, or on counters.
- pred_req=0: pred_valid is 0 the next cycle; pred_taken holds its last value.

## Timing
- Reset (asynchronous, immediate): every entry = 01; pred_valid=0, pred_taken=0, mispredict=0, num_branches=0, num_mispredicts=0.
- Prediction latency 1 cycle: pred_req at edge N is sampled, and pred_valid/pred_taken are valid after edge N.
- Update latency: the entry holds its new value after the sampling edge; a pred_req on the next cycle sees it.
- mispredict is high for exactly one cycle after each mispredicting upd_valid; back-to-back mispredicting updates hold it high continuously.
- Counters reflect an update one cycle after upd_valid.
- Reset asserted mid-operation clears all state immediately, including a pending pred_valid or mispredict. The first sample after deassertion uses reset-state entries.
- No stalls or backpressure: a request or update is accepted every cycle.

## Test plan
- Reset then pred_req with pred_pc=0x100: pred_valid=1, pred_taken=0 next cycle; all counters 0, mispredict 0.
- Two upd_valid updates to 0x100 with upd_br_en=1 and upd_pred_taken=0: the first raises mispredict and moves the entry 01→10, predicting taken; the second moves it to 11 with mispredict still 1. Result: num_branches=2, num_mispredicts=2.
- Saturation: four further taken updates at 0x100 keep the entry at 11. Then one not-taken update gives 10, still predicting taken; a second gives 01, predicting not-taken.
- Aliasing: train 0x100 to taken, then predict 0x200 (same index for INDEX_BITS=6): pred_taken=1. Predict 0x104: pred_taken=0.
- Same cycle: pred_req and upd_valid both at 0x180, with the entry at 01 and upd_br_en=1. pred_taken=0 (old value); the next request returns 1.
- Flush and reset: pred_req+flush gives pred_valid=0. Assert rst for one cycle mid-stream after training: entries return to 01, counters to 0, and the mispredict pulse is cancelled.
